// File: rtl/fifo_burst_writer_pkg.sv
// Shared definitions for the FIFO write-side traffic source and its read-side checker.
package fifo_burst_writer_pkg;

  localparam int unsigned DATASIZE     = 8;
  localparam int unsigned ADDRSIZE     = 10;
  localparam int unsigned WRITE_PERIOD = 2;
  localparam int unsigned BURST_LENGTH = 1024;
  localparam int unsigned WR_CNT_W     = $clog2(BURST_LENGTH + 1);

  // Feedback taps (bits 7,5,4,3) for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;

endpackage

// File: rtl/fifo_burst_writer_pattern_gen.sv
// Next data word for the burst pattern; shared with the read-side checker to predict data.
module fifo_pattern_gen
  import fifo_burst_writer_pkg::*;
(
  input  logic [DATASIZE-1:0] cur,
  input  logic                mode,
  output logic [DATASIZE-1:0] nxt
);

  always_comb begin
    if (mode) begin
      nxt = {cur[DATASIZE-2:0], ^(cur & DATASIZE'(LFSR_TAPS))};
    end else begin
      nxt = cur + DATASIZE'(1);
    end
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Burst write traffic source: paced, stall-aware writes of a predictable pattern into the FIFO.
module fifo_burst_writer #(
  parameter int unsigned WRITE_PERIOD = fifo_burst_writer_pkg::WRITE_PERIOD,
  parameter int unsigned BURST_LENGTH = fifo_burst_writer_pkg::BURST_LENGTH,
  parameter int unsigned CNT_W        = $clog2(BURST_LENGTH + 1)
) (
  input  logic                                    wclk,
  input  logic                                    wrst_n,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic                                    pattern_sel,
  input  logic [fifo_burst_writer_pkg::DATASIZE-1:0] seed,
  input  logic                                    wfull,
  output logic                                    winc,
  output logic [fifo_burst_writer_pkg::DATASIZE-1:0] wdata,
  output logic                                    busy,
  output logic                                    done,
  output logic [CNT_W-1:0]                        words_written,
  output logic [15:0]                             stall_cycles
);

  import fifo_burst_writer_pkg::*;

  localparam int unsigned GAP_W = (WRITE_PERIOD > 1) ? $clog2(WRITE_PERIOD) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(WRITE_PERIOD - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LENGTH - 1);

  wr_state_t           state_q, state_d;
  logic [DATASIZE-1:0] wdata_q, wdata_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [15:0]         stall_q, stall_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATASIZE-1:0] nxt_word;

  fifo_pattern_gen u_pattern_gen (
    .cur  (wdata_q),
    .mode (mode_q),
    .nxt  (nxt_word)
  );

  // Combinational so a falling wfull issues the write in the same cycle
  assign winc = (state_q == WRITE) && (gap_q == '0) && !wfull && !abort;

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    words_d = words_q;
    stall_d = stall_q;
    gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d = WRITE;
          wdata_d = (pattern_sel && (seed == '0)) ? DATASIZE'(1) : seed;
          mode_d  = pattern_sel;
          words_d = '0;
          stall_d = '0;
          gap_d   = '0;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (winc) begin
          words_d = words_q + CNT_W'(1);
          wdata_d = nxt_word;
          gap_d   = GAP_RELOAD;
          if (words_q == BURST_LAST) begin
            state_d = DONE;
          end
        end else if ((gap_q == '0) && wfull && (stall_q != '1)) begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      wdata_q <= '0;
      mode_q  <= 1'b0;
      words_q <= '0;
      stall_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      words_q <= words_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
    end
  end

  assign wdata         = wdata_q;
  assign busy          = (state_q == WRITE);
  assign done          = (state_q == DONE);
  assign words_written = words_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Randomized bench for fifo_burst_writer against a sequence/slot-timing reference model.
module tb_fifo_burst_writer;

  localparam int BL  = 1024;
  localparam int WP  = 2;
  localparam int SBL = 5;

  logic        wclk = 1'b0, wrst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, pattern_sel = 1'b0, wfull = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        winc, busy, done;
  logic [7:0]  wdata;
  logic [10:0] words_written;
  logic [15:0] stall_cycles;

  logic        s_start = 1'b0, s_abort = 1'b0, s_sel = 1'b0, s_wfull = 1'b0;
  logic [7:0]  s_seed = 8'h00;
  logic        s_winc, s_busy, s_done;
  logic [7:0]  s_wdata;
  logic [2:0]  s_words;
  logic [15:0] s_stall;

  fifo_burst_writer dut (
    .wclk(wclk), .wrst_n(wrst_n), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .seed(seed), .wfull(wfull), .winc(winc),
    .wdata(wdata), .busy(busy), .done(done), .words_written(words_written),
    .stall_cycles(stall_cycles)
  );

  fifo_burst_writer #(.WRITE_PERIOD(1), .BURST_LENGTH(SBL)) dut_b2b (
    .wclk(wclk), .wrst_n(wrst_n), .start(s_start), .abort(s_abort),
    .pattern_sel(s_sel), .seed(s_seed), .wfull(s_wfull), .winc(s_winc),
    .wdata(s_wdata), .busy(s_busy), .done(s_done), .words_written(s_words),
    .stall_cycles(s_stall)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int         wt[$];
  logic [7:0] sq[$];
  int         st[$];
  bit         fh[int];

  always @(posedge wclk) cyc <= cyc + 1;

  // Log every accepted write (winc stable between input drive and next edge)
  always @(negedge wclk) begin
    fh[cyc] = wfull;
    if (winc === 1'b1) begin wq.push_back(wdata); wt.push_back(cyc); end
    if (s_winc === 1'b1) begin sq.push_back(s_wdata); st.push_back(cyc); end
  end

  function automatic logic [7:0] pat_next(input logic [7:0] c, input bit m);
    if (m) return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    return c + 8'd1;
  endfunction

  function automatic logic [7:0] first_word(input logic [7:0] sd, input bit m);
    return (m && sd == 8'h00) ? 8'h01 : sd;
  endfunction

  // Index of first wrong word in the log, or -1 when the whole burst matches
  function automatic int seq_bad(input logic [7:0] sd, input bit m);
    logic [7:0] e;
    e = first_word(sd, m);
    foreach (wq[i]) begin
      if (wq[i] !== e) return i;
      e = pat_next(e, m);
    end
    return -1;
  endfunction

  task automatic clear_log();
    wq.delete(); wt.delete(); sq.delete(); st.delete();
  endtask

  task automatic do_start(input bit sel, input logic [7:0] sd, output int acc);
    @(posedge wclk); #1 start = 1'b1; pattern_sel = sel; seed = sd;
    @(posedge wclk); #1 start = 1'b0; acc = cyc;
    pattern_sel = ~sel; seed = 8'($urandom);
  endtask

  task automatic do_abort();
    @(posedge wclk); #1 abort = 1'b1;
    @(posedge wclk); #1 abort = 1'b0;
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge wclk);
      if (wq.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge wclk); #1;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b exp 0", winc); end
    checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", wdata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy %b done %b exp 0 0", busy, done); end
    checks++; if (words_written !== 11'd0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_counters words %0d stall %0d exp 0 0", words_written, stall_cycles); end
    @(negedge wclk); wrst_n = 1'b1;
    repeat (5) @(posedge wclk);
    checks++; if (wq.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle writes %0d busy %b exp 0 0", wq.size(), busy); end
  endtask

  task automatic test_burst(input string nm, input bit sel, input logic [7:0] sd);
    int acc, bad, gapbad;
    bit ok;
    clear_log();
    do_start(sel, sd, acc);
    wait_done(20000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_done_timeout got done=%b exp 1", nm, done); end
    checks++; if (wq.size() != BL) begin errors++; $display("FAIL %s_count got %0d exp %0d", nm, wq.size(), BL); end
    bad = seq_bad(sd, sel);
    checks++; if (bad >= 0) begin errors++; $display("FAIL %s_data index %0d got %h", nm, bad, wq[bad]); end
    checks++; if (wt.size() == 0 || wt[0] != acc) begin errors++; $display("FAIL %s_latency first write cycle %0d exp %0d", nm, (wt.size() != 0) ? wt[0] : -1, acc); end
    gapbad = -1;
    for (int i = 1; i < wt.size(); i++) if (gapbad < 0 && wt[i] - wt[i-1] != WP) gapbad = i;
    checks++; if (gapbad >= 0) begin errors++; $display("FAIL %s_pacing at write %0d spacing %0d exp %0d", nm, gapbad, wt[gapbad] - wt[gapbad-1], WP); end
    checks++; if (words_written !== 11'(BL) || stall_cycles !== 16'd0) begin errors++; $display("FAIL %s_counters words %0d stall %0d exp %0d 0", nm, words_written, stall_cycles, BL); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL %s_end_flags busy %b done %b exp 0 1", nm, busy, done); end
  endtask

  task automatic test_incrementing();
    test_burst("inc_zero", 1'b0, 8'h00);
    test_burst("inc_rand", 1'b0, 8'($urandom));
    do_abort();
    @(negedge wclk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_in_done done %b busy %b exp 0 0", done, busy); end
  endtask

  task automatic test_lfsr();
    int acc;
    bit ok;
    test_burst("lfsr_one", 1'b1, 8'h01);
    test_burst("lfsr_rand", 1'b1, 8'($urandom_range(1, 255)));
    clear_log();
    do_start(1'b1, 8'h00, acc);
    wait_writes(3, ok);
    checks++; if (!ok || wq[0] !== 8'h01 || wq[1] !== 8'h02 || wq[2] !== 8'h04) begin
      errors++; $display("FAIL lfsr_zero_seed got %h %h %h exp 01 02 04", wq[0], wq[1], wq[2]);
    end
    do_abort();
  endtask

  task automatic test_stall();
    int acc, bad;
    bit ok;
    logic [7:0] sd, e5;
    sd = 8'($urandom);
    e5 = sd;
    for (int i = 0; i < 4; i++) e5 = pat_next(e5, 1'b0);
    clear_log();
    do_start(1'b0, sd, acc);
    wait_writes(4, ok);
    #1 wfull = 1'b1;
    repeat (6) @(negedge wclk);
    checks++; if (winc !== 1'b0 || wdata !== e5) begin errors++; $display("FAIL stall_hold winc %b wdata %h exp 0 %h", winc, wdata, e5); end
    checks++; if (stall_cycles !== 16'd4) begin errors++; $display("FAIL stall_midcount got %0d exp 4", stall_cycles); end
    repeat (6) @(posedge wclk);
    #1 wfull = 1'b0;
    wait_done(20000, ok);
    checks++; if (!ok || stall_cycles !== 16'd10) begin errors++; $display("FAIL stall_count got %0d exp 10 (done %b)", stall_cycles, done); end
    checks++; if (wt.size() < 5 || wt[4] - wt[3] != 12) begin errors++; $display("FAIL stall_resume spacing %0d exp 12", (wt.size() >= 5) ? wt[4] - wt[3] : -1); end
    bad = seq_bad(sd, 1'b0);
    checks++; if (wq.size() != BL || bad >= 0) begin errors++; $display("FAIL stall_data count %0d bad index %0d exp %0d -1", wq.size(), bad, BL); end
  endtask

  // Model: a slot opens WP cycles after the previous write; it writes unless wfull, else it stalls
  task automatic test_random_stall();
    int acc, prev, n, t, exp_stall, bad;
    int ew[$];
    bit ok;
    logic [7:0] sd;
    sd = 8'($urandom_range(1, 255));
    clear_log();
    do_start(1'b1, sd, acc);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      wfull = ($urandom_range(0, 3) == 0);
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rstall_timeout got done=%b exp 1", done); end
    prev = acc - WP; n = 0; exp_stall = 0; t = acc;
    while (n < BL && fh.exists(t)) begin
      if (t >= prev + WP) begin
        if (fh[t]) exp_stall++;
        else begin ew.push_back(t); prev = t; n++; end
      end
      t++;
    end
    bad = (ew.size() == wt.size()) ? -1 : 0;
    foreach (ew[i]) if (bad < 0 && i < wt.size() && ew[i] != wt[i]) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL rstall_timing write %0d model size %0d got size %0d", bad, ew.size(), wt.size()); end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL rstall_count got %0d exp %0d", stall_cycles, exp_stall); end
    bad = seq_bad(sd, 1'b1);
    checks++; if (wq.size() != BL || bad >= 0) begin errors++; $display("FAIL rstall_data count %0d bad index %0d exp %0d -1", wq.size(), bad, BL); end
  endtask

  task automatic test_abort();
    int acc;
    bit ok;
    logic [7:0] sd;
    clear_log();
    do_start(1'b0, 8'($urandom), acc);
    wait_writes(300, ok);
    #1 abort = 1'b1;
    @(posedge wclk); #1 abort = 1'b0;
    @(negedge wclk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || winc !== 1'b0) begin errors++; $display("FAIL abort_state busy %b done %b winc %b exp 0 0 0", busy, done, winc); end
    checks++; if (words_written !== 11'd300) begin errors++; $display("FAIL abort_words got %0d exp 300", words_written); end
    repeat (5) @(posedge wclk);
    checks++; if (wq.size() != 300) begin errors++; $display("FAIL abort_no_more_writes got %0d exp 300", wq.size()); end
    sd = 8'($urandom);
    clear_log();
    do_start(1'b1, sd, acc);
    @(negedge wclk);
    checks++; if (words_written !== 11'd0 || winc !== 1'b1 || wdata !== first_word(sd, 1'b1)) begin
      errors++; $display("FAIL abort_restart words %0d winc %b wdata %h exp 0 1 %h", words_written, winc, wdata, first_word(sd, 1'b1));
    end
    do_abort();
  endtask

  task automatic test_back_to_back();
    int acc, bad;
    bit ok;
    logic [7:0] sd, e;
    bit m;
    sd = 8'($urandom);
    clear_log();
    do_start(1'b0, sd, acc);
    wait_writes(100, ok);
    #1 start = 1'b1; seed = ~sd; pattern_sel = 1'b1;
    @(posedge wclk); #1 start = 1'b0;
    wait_done(20000, ok);
    bad = seq_bad(sd, 1'b0);
    checks++; if (!ok || wq.size() != BL || bad >= 0) begin errors++; $display("FAIL start_ignored done %b count %0d bad %0d exp 1 %0d -1", done, wq.size(), bad, BL); end
    do_abort();
    clear_log();
    @(posedge wclk); #1 start = 1'b1; abort = 1'b1;
    @(posedge wclk); #1 start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge wclk);
    checks++; if (busy !== 1'b0 || wq.size() != 0) begin errors++; $display("FAIL start_abort_idle busy %b writes %0d exp 0 0", busy, wq.size()); end
    sd = 8'($urandom); m = 1'($urandom);
    @(posedge wclk); #1 s_start = 1'b1; s_seed = sd; s_sel = m;
    @(posedge wclk); #1 s_start = 1'b0; acc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge wclk); #1;
      if (s_done === 1'b1) begin ok = 1'b1; break; end
    end
    bad = (sq.size() == SBL) ? -1 : 0;
    e = first_word(sd, m);
    foreach (sq[i]) begin
      if (bad < 0 && (sq[i] !== e || st[i] != acc + i)) bad = i;
      e = pat_next(e, m);
    end
    checks++; if (!ok || bad >= 0) begin errors++; $display("FAIL period1_burst done %b count %0d bad %0d exp 1 %0d -1", s_done, sq.size(), bad, SBL); end
    checks++; if (s_words !== 3'(SBL)) begin errors++; $display("FAIL period1_words got %0d exp %0d", s_words, SBL); end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    clear_log();
    do_start(1'b0, 8'($urandom), acc);
    wait_writes(50, ok);
    @(posedge wclk); #2;
    checks++; if (winc !== 1'b1) begin errors++; $display("FAIL rstmid_pre winc %b exp 1", winc); end
    wrst_n = 1'b0;
    #1;
    checks++; if (winc !== 1'b0 || busy !== 1'b0 || wdata !== 8'h00) begin errors++; $display("FAIL rstmid_async winc %b busy %b wdata %h exp 0 0 00", winc, busy, wdata); end
    checks++; if (words_written !== 11'd0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL rstmid_counters words %0d stall %0d exp 0 0", words_written, stall_cycles); end
    @(negedge wclk); wrst_n = 1'b1;
    repeat (5) @(posedge wclk); #1;
    checks++; if (wq.size() != 50 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_idle writes %0d busy %b done %b exp 50 0 0", wq.size(), busy, done); end
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_lfsr();
    test_stall();
    test_random_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
